// File: rtl/message_extractor.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// message_extractor
//
// Recovers a hidden message from a stream of stego image bytes. Each carrier
// byte contributes its three least-significant bits to the message, LSB first
// (pix_data[0] is the earliest message bit). Message bytes are emitted
// through a valid/ready handshake.
//
// Parameters:
//   MSG_LEN       number of message bytes to recover (1..64)
//   NUM_CARRIERS  derived: ceil(MSG_LEN*8/3) carrier bytes per extraction
//
// Ports:
//   clk        clock, all logic on the rising edge
//   HRESET     synchronous active-high reset
//   start      one-cycle pulse beginning an extraction (ignored unless idle)
//   pix_data   stego image byte (R,G,B interleaved stream order)
//   pix_valid  pix_data is valid
//   pix_ready  extractor accepts pix_data this cycle
//   msg_byte   recovered message byte
//   msg_valid  msg_byte is valid
//   msg_ready  downstream accepts msg_byte
//   busy       extraction in progress (low during the done cycle)
//   done       one-cycle pulse after the last message byte is accepted
//   msg_chk    (only with MSG_EXTRACT_CHECKSUM_EN) XOR of all message bytes
//              of the current extraction
//
// Build option: define MSG_EXTRACT_CHECKSUM_EN to add the msg_chk output.
// -----------------------------------------------------------------------------
module message_extractor #(
  parameter  int MSG_LEN      = 6,
  localparam int NUM_CARRIERS = (MSG_LEN * 8 + 2) / 3
) (
  input  logic       clk,
  input  logic       HRESET,
  input  logic       start,
  input  logic [7:0] pix_data,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [7:0] msg_byte,
  output logic       msg_valid,
  input  logic       msg_ready,
  output logic       busy,
  output logic       done
`ifdef MSG_EXTRACT_CHECKSUM_EN
  ,
  output logic [7:0] msg_chk
`endif
);

  localparam int CW = $clog2(NUM_CARRIERS + 1);
  localparam int BW = $clog2(MSG_LEN + 1);

  localparam logic [CW-1:0] CARRIER_TOTAL = CW'(NUM_CARRIERS);
  localparam logic [BW-1:0] BYTE_TOTAL    = BW'(MSG_LEN);
  localparam logic [BW-1:0] LAST_BYTE     = BW'(MSG_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXTRACT,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [10:0]   acc_q, acc_d;
  logic [3:0]    acnt_q, acnt_d;
  logic [CW-1:0] carrierCnt_q, carrierCnt_d;
  logic [BW-1:0] byteCnt_q, byteCnt_d;
  logic          pixXfer;
  logic          byteXfer;
`ifdef MSG_EXTRACT_CHECKSUM_EN
  logic [7:0]    chk_q, chk_d;
`endif

  // Only the three carrier LSBs hold message data; the upper bits are dropped.
  logic unused_pixHigh;
  assign unused_pixHigh = ^pix_data[7:3];

  always_ff @(posedge clk) begin
    if (HRESET) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      acnt_q       <= '0;
      carrierCnt_q <= '0;
      byteCnt_q    <= '0;
`ifdef MSG_EXTRACT_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      acnt_q       <= acnt_d;
      carrierCnt_q <= carrierCnt_d;
      byteCnt_q    <= byteCnt_d;
`ifdef MSG_EXTRACT_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  // The accumulator only ever holds bits below acnt (everything above has
  // been shifted out or cleared), so new carrier bits can simply be OR-ed in.
  // pix_ready needs acnt<8 and msg_valid needs acnt>=8, so the two transfers
  // can never happen in the same cycle.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    acnt_d       = acnt_q;
    carrierCnt_d = carrierCnt_q;
    byteCnt_d    = byteCnt_q;
`ifdef MSG_EXTRACT_CHECKSUM_EN
    chk_d        = chk_q;
`endif
    pix_ready    = 1'b0;
    msg_valid    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    pixXfer      = 1'b0;
    byteXfer     = 1'b0;
    msg_byte     = acc_q[7:0];

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = EXTRACT;
          acc_d        = '0;
          acnt_d       = '0;
          carrierCnt_d = '0;
          byteCnt_d    = '0;
`ifdef MSG_EXTRACT_CHECKSUM_EN
          chk_d        = '0;
`endif
        end
      end

      EXTRACT: begin
        busy      = 1'b1;
        pix_ready = (acnt_q < 4'd8) && (carrierCnt_q < CARRIER_TOTAL);
        msg_valid = (acnt_q >= 4'd8) && (byteCnt_q < BYTE_TOTAL);
        pixXfer   = pix_ready && pix_valid;
        byteXfer  = msg_valid && msg_ready;

        if (pixXfer) begin
          acc_d        = acc_q | (11'(pix_data[2:0]) << acnt_q);
          acnt_d       = acnt_q + 4'd3;
          carrierCnt_d = carrierCnt_q + 1'b1;
        end

        if (byteXfer) begin
          acc_d     = acc_q >> 8;
          acnt_d    = acnt_q - 4'd8;
          byteCnt_d = byteCnt_q + 1'b1;
`ifdef MSG_EXTRACT_CHECKSUM_EN
          chk_d     = chk_q ^ acc_q[7:0];
`endif
          // Surplus bits of the final carrier are thrown away here.
          if (byteCnt_q == LAST_BYTE) begin
            state_d = DONE;
            acc_d   = '0;
            acnt_d  = '0;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef MSG_EXTRACT_CHECKSUM_EN
  assign msg_chk = chk_q;
`endif

endmodule

// File: tb/tb_message_extractor.sv
`timescale 1ns/1ps
// Scoreboard bench for message_extractor: the main process issues extractions
// and pushes the bytes a bit-level reference model predicts; a monitor pops
// and compares them whenever the DUT completes a byte handshake.
module tb_message_extractor;

  localparam int MSG_LEN      = 6;
  localparam int NUM_CARRIERS = (MSG_LEN * 8 + 2) / 3;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       HRESET;
  logic       start;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] msg_byte;
  logic       msg_valid;
  logic       msg_ready;
  logic       busy;
  logic       done;

  logic       start1;
  logic [7:0] pixData1;
  logic       pixValid1;
  logic       pixReady1;
  logic [7:0] msgByte1;
  logic       msgValid1;
  logic       msgReady1;
  logic       busy1;
  logic       done1;

`ifdef MSG_EXTRACT_CHECKSUM_EN
  logic [7:0] msg_chk;
  logic [7:0] msgChk1;
`endif

  message_extractor #(.MSG_LEN(MSG_LEN)) dut (
    .clk       (clk),
    .HRESET    (HRESET),
    .start     (start),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .msg_byte  (msg_byte),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .busy      (busy),
    .done      (done)
`ifdef MSG_EXTRACT_CHECKSUM_EN
    ,
    .msg_chk   (msg_chk)
`endif
  );

  message_extractor #(.MSG_LEN(1)) dut1 (
    .clk       (clk),
    .HRESET    (HRESET),
    .start     (start1),
    .pix_data  (pixData1),
    .pix_valid (pixValid1),
    .pix_ready (pixReady1),
    .msg_byte  (msgByte1),
    .msg_valid (msgValid1),
    .msg_ready (msgReady1),
    .busy      (busy1),
    .done      (done1)
`ifdef MSG_EXTRACT_CHECKSUM_EN
    ,
    .msg_chk   (msgChk1)
`endif
  );

  int         checks = 0;
  int         failures = 0;

  logic [7:0] pixQ[$];
  logic [7:0] expQ[$];
  logic [7:0] expChk;
  logic [7:0] monExp;
  int         runLeft = 0;
  bit         doneDue = 1'b0;
  bit         runComplete = 1'b0;
  bit         feederTake;
  int         pixTaken = 0;
  int         throttle = 0;
  int         readyMode = 0;
  bit         stallPrev = 1'b0;
  logic [7:0] stallByte;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Pixel feeder: presents the head of pixQ, optionally with random bubbles.
  always begin
    @(negedge clk);
    feederTake = pix_valid && pix_ready && !HRESET;
    @(posedge clk);
    #1;
    if (feederTake && pixQ.size() > 0) begin
      void'(pixQ.pop_front());
      pixTaken++;
    end
    if (pixQ.size() > 0 && (throttle == 0 || $urandom_range(0, 3) != 0)) begin
      pix_valid = 1'b1;
      pix_data  = pixQ[0];
    end else begin
      pix_valid = 1'b0;
      pix_data  = 8'($urandom);
    end
  end

  // Downstream: always ready, random backpressure, or held off.
  always begin
    @(posedge clk);
    #1;
    case (readyMode)
      0:       msg_ready = 1'b1;
      1:       msg_ready = 1'($urandom_range(0, 1));
      default: msg_ready = 1'b0;
    endcase
  end

  // Monitor: compares handshaked bytes against the scoreboard and checks
  // stall stability, handshake exclusivity and done timing.
  always begin
    @(negedge clk);
    if (!HRESET) begin
      if (stallPrev) begin
        checkOutput("stall_valid_held", 32'(msg_valid), 32'd1);
        checkOutput("stall_byte_held", 32'(msg_byte), 32'(stallByte));
      end
      stallPrev = msg_valid && !msg_ready;
      stallByte = msg_byte;
      if (msg_valid) checkOutput("pix_ready_exclusive", 32'(pix_ready), 32'd0);
      if (doneDue) begin
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("busy_at_done", 32'(busy), 32'd0);
`ifdef MSG_EXTRACT_CHECKSUM_EN
        checkOutput("msg_chk", 32'(msg_chk), 32'(expChk));
`endif
        doneDue     = 1'b0;
        runComplete = 1'b1;
      end else begin
        checkOutput("no_stray_done", 32'(done), 32'd0);
      end
      if (msg_valid && msg_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte", msg_byte);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("msg_byte", 32'(msg_byte), 32'(monExp));
          runLeft--;
          if (runLeft == 0) doneDue = 1'b1;
        end
      end
    end else begin
      stallPrev = 1'b0;
      doneDue   = 1'b0;
    end
  end

  // Reference model: message bit i lives in carrier i/3 at bit i%3, and
  // message byte j collects bits 8j..8j+7 LSB first.
  task automatic applyStimulus(input logic [7:0] pix[$], input int thr,
                               input int rdy, input bit waitDone);
    expChk = 8'h00;
    for (int j = 0; j < MSG_LEN; j++) begin
      logic [7:0] b;
      for (int k = 0; k < 8; k++) begin
        int         bitIdx;
        logic [7:0] p;
        bitIdx = 8 * j + k;
        p      = pix[bitIdx / 3];
        b[k]   = p[bitIdx % 3];
      end
      expQ.push_back(b);
      expChk ^= b;
    end
    runLeft     = MSG_LEN;
    runComplete = 1'b0;
    throttle    = thr;
    readyMode   = rdy;
    pixTaken    = 0;
    pixQ        = pix;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    if (waitDone) waitRun();
  endtask

  task automatic waitRun();
    int n;
    n = 0;
    while (!runComplete && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("run_complete", 32'(runComplete), 32'd1);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_pix_ready"}, 32'(pix_ready), 32'd0);
    checkOutput({tag, "_msg_valid"}, 32'(msg_valid), 32'd0);
    checkOutput({tag, "_msg_byte"}, 32'(msg_byte), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
`ifdef MSG_EXTRACT_CHECKSUM_EN
    checkOutput({tag, "_msg_chk"}, 32'(msg_chk), 32'd0);
`endif
  endtask

  initial begin
    logic [7:0] pq[$];
    logic [7:0] m;
    logic [7:0] p;
    int         idx;
    int         n;
    int         u1Pix;
    int         u1Bytes;
    int         u1Done;

    HRESET    = 1'b1;
    start     = 1'b0;
    pix_data  = 8'h00;
    pix_valid = 1'b0;
    msg_ready = 1'b0;
    start1    = 1'b0;
    pixData1  = 8'h00;
    pixValid1 = 1'b0;
    msgReady1 = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkResetOutputs("reset");
    checkOutput("reset_u1_pix_ready", 32'(pixReady1), 32'd0);
    checkOutput("reset_u1_msg_valid", 32'(msgValid1), 32'd0);
    HRESET = 1'b0;
    @(posedge clk);
    #2;

    $display("[TB] constant 0xAD carriers");
    pq.delete();
    for (int c = 0; c < NUM_CARRIERS; c++) pq.push_back(8'hAD);
    applyStimulus(pq, 0, 0, 1'b1);

    $display("[TB] carriers encoding six 0x41 bytes");
    pq.delete();
    m = 8'h41;
    for (int c = 0; c < NUM_CARRIERS; c++) begin
      p = 8'hF8;
      for (int b = 0; b < 3; b++) begin
        idx  = 3 * c + b;
        p[b] = m[idx % 8];
      end
      pq.push_back(p);
    end
    applyStimulus(pq, 0, 0, 1'b1);

    $display("[TB] downstream stall on first byte");
    pq.delete();
    for (int c = 0; c < NUM_CARRIERS; c++) pq.push_back(8'hAD);
    applyStimulus(pq, 0, 2, 1'b0);
    n = 0;
    while (!msg_valid && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("first_byte_pending", 32'(msg_valid), 32'd1);
    repeat (5) begin
      @(posedge clk);
      #2;
      checkOutput("stall_pix_ready", 32'(pix_ready), 32'd0);
      checkOutput("stall_msg_byte", 32'(msg_byte), 32'h6D);
    end
    readyMode = 0;
    waitRun();

    $display("[TB] random carriers with random handshakes");
    for (int r = 0; r < 4; r++) begin
      pq.delete();
      for (int c = 0; c < NUM_CARRIERS; c++) pq.push_back(8'($urandom));
      applyStimulus(pq, 1, 1, 1'b1);
    end

    $display("[TB] reset after 7 carriers");
    pq.delete();
    for (int c = 0; c < NUM_CARRIERS; c++) pq.push_back(8'($urandom));
    applyStimulus(pq, 0, 0, 1'b0);
    n = 0;
    while (pixTaken < 7 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("seven_pixels_taken", 32'(pixTaken), 32'd7);
    HRESET = 1'b1;
    pixQ.delete();
    expQ.delete();
    runLeft = 0;
    @(posedge clk);
    #2;
    checkResetOutputs("abort");
    HRESET = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    pq.delete();
    for (int c = 0; c < NUM_CARRIERS; c++) pq.push_back(8'($urandom));
    applyStimulus(pq, 0, 0, 1'b1);

    $display("[TB] start pulsed during extraction");
    pq.delete();
    for (int c = 0; c < NUM_CARRIERS; c++) pq.push_back(8'($urandom));
    applyStimulus(pq, 1, 1, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    checkOutput("busy_after_restart", 32'(busy), 32'd1);
    waitRun();

    $display("[TB] single-byte extractor");
    start1 = 1'b1;
    @(posedge clk);
    #2;
    start1    = 1'b0;
    pixValid1 = 1'b1;
    pixData1  = 8'hFF;
    u1Pix     = 0;
    u1Bytes   = 0;
    u1Done    = 0;
    repeat (20) begin
      @(negedge clk);
      if (pixValid1 && pixReady1) u1Pix++;
      if (msgValid1) begin
        u1Bytes++;
        checkOutput("u1_msg_byte", 32'(msgByte1), 32'hFF);
      end
      if (done1) begin
        u1Done++;
`ifdef MSG_EXTRACT_CHECKSUM_EN
        checkOutput("u1_msg_chk", 32'(msgChk1), 32'hFF);
`endif
      end
    end
    checkOutput("u1_pixels_taken", 32'(u1Pix), 32'd3);
    checkOutput("u1_byte_count", 32'(u1Bytes), 32'd1);
    checkOutput("u1_done_count", 32'(u1Done), 32'd1);
    checkOutput("u1_pix_ready_after", 32'(pixReady1), 32'd0);
    pixValid1 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected bench completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
